// File: rtl/sample_vote_accumulator_pkg.sv
// Shared definitions for the sample vote accumulator: FSM state encoding.
package sample_vote_accumulator_pkg;

  typedef enum logic [1:0] {
    VoteIdle   = 2'd0,
    VoteAccum  = 2'd1,
    VoteArgmax = 2'd2,
    VoteDone   = 2'd3
  } vote_state_e;

endpackage

// File: rtl/score_acc_bank.sv
// Bank of out_dim signed score accumulators with synchronous clear and accept enable.
module score_acc_bank #(
  parameter int unsigned output_bitlength = 8,
  parameter int unsigned out_dim          = 2,
  parameter int unsigned acc_bitlength    = 12
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               clear,
  input  logic                               enable,
  input  logic [out_dim*output_bitlength-1:0] score,
  output logic [out_dim*acc_bitlength-1:0]    acc
);

  logic signed [acc_bitlength-1:0] acc_q [out_dim];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < out_dim; i++) acc_q[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < out_dim; i++) acc_q[i] <= '0;
    end else if (enable) begin
      // Sign-extend each class score to the accumulator width before adding.
      for (int i = 0; i < out_dim; i++) begin
        acc_q[i] <= acc_q[i] +
                    acc_bitlength'(signed'(score[i*output_bitlength +: output_bitlength]));
      end
    end
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < out_dim; i++) acc[i*acc_bitlength +: acc_bitlength] = acc_q[i];
  end

endmodule

// File: rtl/sample_vote_accumulator.sv
// Accumulates num_samples score vectors per class, then picks the argmax with one
// sequential comparator and reports the winner with a one-cycle done pulse.
module sample_vote_accumulator
  import sample_vote_accumulator_pkg::*;
#(
  parameter int unsigned output_bitlength = 8,
  parameter int unsigned out_dim          = 2,
  parameter int unsigned num_samples      = 16,
  localparam int unsigned acc_bitlength   = output_bitlength + $clog2(num_samples),
  localparam int unsigned cls_bitlength   = (out_dim > 1) ? $clog2(out_dim) : 1
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                start,
  input  logic [out_dim*output_bitlength-1:0] ScoreI,
  input  logic                                ScoreValid,
  output logic                                ScoreReady,
  output logic                                busy,
  output logic                                done,
  output logic [cls_bitlength-1:0]            ClassO,
  output logic [acc_bitlength-1:0]            MaxScoreO
);

  localparam int unsigned cnt_bitlength = (num_samples > 1) ? $clog2(num_samples) : 1;
  localparam logic [cnt_bitlength-1:0] last_cnt = cnt_bitlength'(num_samples - 1);
  localparam logic [cls_bitlength-1:0] last_idx = cls_bitlength'(out_dim - 1);

  vote_state_e state_q, state_d;
  logic [cnt_bitlength-1:0] cnt_q, cnt_d;
  logic [cls_bitlength-1:0] idx_q, idx_d, best_idx_q, best_idx_d, class_q, class_d;
  logic signed [acc_bitlength-1:0] best_val_q, best_val_d, max_q, max_d;
  logic signed [acc_bitlength-1:0] acc_sel, acc0_next;
  logic [out_dim*acc_bitlength-1:0] acc_flat;
  logic accept, clear, take;

  assign accept = (state_q == VoteAccum) && ScoreValid;
  assign clear  = (state_q == VoteIdle) && start;

  score_acc_bank #(
    .output_bitlength(output_bitlength),
    .out_dim         (out_dim),
    .acc_bitlength   (acc_bitlength)
  ) u_bank (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .enable(accept),
    .score (ScoreI),
    .acc   (acc_flat)
  );

  assign acc_sel   = acc_flat[idx_q*acc_bitlength +: acc_bitlength];
  assign take      = acc_sel > best_val_q;
  // Only used when there is a single class and ARGMAX is skipped.
  assign acc0_next = signed'(acc_flat[acc_bitlength-1:0]) +
                     acc_bitlength'(signed'(ScoreI[output_bitlength-1:0]));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
    class_d    = class_q;
    max_d      = max_q;
    unique case (state_q)
      VoteIdle: begin
        if (start) begin
          state_d = VoteAccum;
          cnt_d   = '0;
        end
      end
      VoteAccum: begin
        if (ScoreValid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == last_cnt) begin
            if (out_dim == 1) begin
              state_d = VoteDone;
              class_d = '0;
              max_d   = acc0_next;
            end else begin
              state_d = VoteArgmax;
              idx_d   = '0;
            end
          end
        end
      end
      VoteArgmax: begin
        idx_d = idx_q + 1'b1;
        // First ARGMAX cycle seeds from class 0 once the final sample has landed.
        if (idx_q == '0) begin
          best_idx_d = '0;
          best_val_d = acc_sel;
        end else begin
          if (take) begin
            best_idx_d = idx_q;
            best_val_d = acc_sel;
          end
          if (idx_q == last_idx) begin
            state_d = VoteDone;
            class_d = take ? idx_q : best_idx_q;
            max_d   = take ? acc_sel : best_val_q;
          end
        end
      end
      VoteDone: state_d = VoteIdle;
      default:  state_d = VoteIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= VoteIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      best_idx_q <= '0;
      best_val_q <= '0;
      class_q    <= '0;
      max_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      best_idx_q <= best_idx_d;
      best_val_q <= best_val_d;
      class_q    <= class_d;
      max_q      <= max_d;
    end
  end

  assign ScoreReady = (state_q == VoteAccum);
  assign busy       = (state_q != VoteIdle);
  assign done       = (state_q == VoteDone);
  assign ClassO     = class_q;
  assign MaxScoreO  = max_q;

endmodule

// File: tb/tb_sample_vote_accumulator.sv
// Scoreboard bench: stimulus pushes expected results, a monitor pops them on each done pulse.
module tb_sample_vote_accumulator;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] ScoreI;
  logic        ScoreValid;
  logic        ScoreReady;
  logic        busy;
  logic        done;
  logic [0:0]  ClassO;
  logic [9:0]  MaxScoreO;

  sample_vote_accumulator #(
    .output_bitlength(8),
    .out_dim         (2),
    .num_samples     (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .ScoreI    (ScoreI),
    .ScoreValid(ScoreValid),
    .ScoreReady(ScoreReady),
    .busy      (busy),
    .done      (done),
    .ClassO    (ClassO),
    .MaxScoreO (MaxScoreO)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [0:0] cls;
    logic [9:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   accept_edge = -100;
  logic done_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: pops one expected result per done pulse.
  always @(negedge clock) begin
    if (reset) begin
      if (ScoreValid && ScoreReady) accept_edge = cyc + 1;
      if (done) begin
        check("done_single_cycle", 32'(done_prev), 32'd0);
        check("done_latency", cyc - accept_edge, 32'd2);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got class %0d score %0h want no done", ClassO, MaxScoreO);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("class", 32'(ClassO), 32'(e.cls));
          check("max_score", 32'(MaxScoreO), 32'(e.val));
        end
      end
      done_prev = done;
    end else begin
      done_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic cls, input logic [9:0] val);
    exp_t e;
    e.cls = cls;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input int c0, input int c1);
    ScoreI     = {8'(c1), 8'(c0)};
    ScoreValid = 1'b1;
    check("ready_when_sending", 32'(ScoreReady), 32'd1);
    tick();
    ScoreValid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    check("finish_within_bound", 32'(busy), 32'd0);
  endtask

  task automatic run4(input int c0, input int c1);
    do_start();
    for (int i = 0; i < 4; i++) send(c0, c1);
    wait_idle();
  endtask

  initial begin
    logic pat [7];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    reset = 1'b0;
    start = 1'b0;
    ScoreValid = 1'b0;
    ScoreI = '0;

    // Reset state
    #2;
    check("rst_ready", 32'(ScoreReady), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_class", 32'(ClassO), 32'd0);
    check("rst_max", 32'(MaxScoreO), 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_ready", 32'(ScoreReady), 32'd0);

    // Basic decision
    push(1'b0, 10'd40);
    run4(10, 3);
    check("hold_class", 32'(ClassO), 32'd0);
    check("hold_max", 32'(MaxScoreO), 32'd40);

    // Negative extremes, then positive extreme
    push(1'b1, 10'h3FC);
    run4(-128, -1);
    push(1'b0, 10'd508);
    run4(127, 0);

    // Tie resolves to lowest index
    push(1'b0, 10'd20);
    run4(5, 5);

    // Gaps in valid, start pulsed mid-accumulation, junk on idle cycles
    push(1'b1, 10'd8);
    do_start();
    for (int i = 0; i < 7; i++) begin
      if (pat[i]) begin
        send(1, 2);
      end else begin
        ScoreI     = {8'h7F, 8'h80};
        ScoreValid = 1'b0;
        if (i == 1) start = 1'b1;
        tick();
        start = 1'b0;
      end
    end
    wait_idle();

    // Reset mid-operation discards partial sums
    do_start();
    check("start_keeps_class", 32'(ClassO), 32'd1);
    check("start_keeps_max", 32'(MaxScoreO), 32'd8);
    send(9, 1);
    send(9, 1);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(ScoreReady), 32'd0);
    check("midrst_class", 32'(ClassO), 32'd0);
    check("midrst_max", 32'(MaxScoreO), 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    push(1'b1, 10'd28);
    run4(0, 7);

    repeat (3) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
